pipe_stage_skid_reg: RTL

// - Generic inter-stage pipeline register for the rv32i core (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries an opaque DATA_W payload with a valid/ready handshake.
// - Optional 2-entry skid buffer gives full throughput with a registered in_ready.
// - Flush empties the stage, drives the NOP payload and emits a one-cycle flushed marker downstream.

---
 rtl/pipe_stage_skid_reg.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_reg
// Description : Inter-stage pipeline register with valid/ready handshake.
//               SKID=1 adds a second (skid) entry so in_ready can be
//               registered while still sustaining one payload per cycle.
//               Flush empties the stage, reloads the NOP payload and raises
//               out_flushed for one cycle.
//               Optional performance counters are built only when the macro
//               PIPE_STAGE_PERF_EN is defined; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
    parameter int unsigned        DATA_W      = 256,
    parameter logic [DATA_W-1:0]  NOP_PAYLOAD = '0,
    parameter int unsigned        SKID        = 1,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_flushed,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // State encoding doubles as the entry count driven on occupancy.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_flushed;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // State register: reset and flush both return the stage to EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath-steering decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = S_BUSY;
                        w_load_main = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        // Only reachable with a skid entry: without one,
                        // in_ready in BUSY implies out_ready.
                        if (SKID != 0) begin
                            w_state_nxt = S_FULL;
                            w_load_skid = 1'b1;
                        end
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt      = S_BUSY;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs derived from the current state.
    always_comb begin
        out_valid = (r_state != S_EMPTY);
        occupancy = r_state;
        if (SKID != 0) begin
            // Registered apart from the flush kill term.
            in_ready = (r_state != S_FULL) & ~flush;
        end else begin
            in_ready = ((r_state == S_EMPTY) | out_ready) & ~flush;
        end
    end

    // Payload storage: main feeds out_data, skid catches the overflow beat.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main <= NOP_PAYLOAD;
            r_skid <= NOP_PAYLOAD;
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    // One-cycle marker following each flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flushed <= 1'b0;
        end else begin
            r_flushed <= flush;
        end
    end

    assign out_data    = r_main;
    assign out_flushed = r_flushed;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters; flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!out_valid && (r_bubble_cnt != C_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire
